// File: rtl/dmem_lane_arbiter_pkg.sv
// Shared constants and helpers for the multi-lane dmem arbiter.
// Arbitration mode encodings and the lane-id width helper.
package dmem_arb_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Lane ids need at least one bit even when only one lane exists.
    function automatic int lane_id_w(input int num_lanes);
        return (num_lanes <= 1) ? 1 : $clog2(num_lanes);
    endfunction

endpackage

// File: rtl/dmem_lane_arbiter_if.sv
// Lane-side request/grant bus plus memory-side issue/return signals.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface dmem_lane_arbiter_if #(
    parameter int NUM_LANES = 2,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32
) ();

    logic [NUM_LANES-1:0]        lane_req;
    logic [NUM_LANES-1:0]        lane_we;
    logic [NUM_LANES*ADDR_W-1:0] lane_addr;
    logic [NUM_LANES*DATA_W-1:0] lane_wdata;
    logic [NUM_LANES-1:0]        lane_gnt;
    logic [NUM_LANES-1:0]        lane_rvalid;
    logic [DATA_W-1:0]           lane_rdata;
    logic [ADDR_W-1:0]           address_dmem;
    logic [DATA_W-1:0]           data;
    logic                        wren;
    logic [DATA_W-1:0]           q_dmem;

    modport slave (
        input  lane_req, lane_we, lane_addr, lane_wdata, q_dmem,
        output lane_gnt, lane_rvalid, lane_rdata, address_dmem, data, wren
    );

    modport master (
        output lane_req, lane_we, lane_addr, lane_wdata, q_dmem,
        input  lane_gnt, lane_rvalid, lane_rdata, address_dmem, data, wren
    );

endinterface

// File: rtl/dmem_lane_arbiter_rr_grant.sv
// One-hot grant selection across lanes, round-robin or fixed priority.
// Holds the round-robin pointer; grant is combinational and gated off in reset.
module rr_grant
    import dmem_arb_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int ARB_MODE  = ARB_RR,
    localparam int LW       = lane_id_w(NUM_LANES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] i_req,
    output logic [NUM_LANES-1:0] o_gnt,
    output logic [LW-1:0]        o_gnt_idx,
    output logic                 o_any
);

    logic [LW-1:0]               r_ptr;
    logic [NUM_LANES-1:0]        w_mask;
    logic [NUM_LANES-1:0]        w_req_hi;
    logic [NUM_LANES-1:0]        w_sel;
    logic [NUM_LANES-1:0]        w_pick;
    logic [NUM_LANES:0][LW-1:0]  w_idx_chain;

    assign w_idx_chain[0] = '0;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign w_mask[gi]          = (LW'(gi) >= r_ptr);
            assign w_idx_chain[gi + 1] = w_idx_chain[gi] | (w_pick[gi] ? LW'(gi) : '0);
        end
    endgenerate

    // Lanes at or above the pointer are searched first; if none request, wrap to the lowest.
    assign w_req_hi = i_req & w_mask;
    assign w_sel    = (ARB_MODE == ARB_FIXED || w_req_hi == '0) ? i_req : w_req_hi;
    assign w_pick   = reset ? (w_sel & (~w_sel + NUM_LANES'(1))) : '0;

    assign o_gnt     = w_pick;
    assign o_gnt_idx = w_idx_chain[NUM_LANES];
    assign o_any     = |w_pick;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (ARB_MODE == ARB_RR && o_any) begin
            r_ptr <= (o_gnt_idx == LW'(NUM_LANES - 1)) ? '0 : o_gnt_idx + LW'(1);
        end
    end

endmodule

// File: rtl/dmem_lane_arbiter.sv
// Shares one single-ported dmem between NUM_LANES issue lanes: grant, registered
// issue stage, and an in-order return pipeline that steers load data to its lane.
module dmem_lane_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int READ_LAT  = 1,
    parameter int ARB_MODE  = ARB_RR
) (
    input logic                 clock,
    input logic                 reset,
    dmem_lane_arbiter_if.slave  bus
);

    localparam int LW = lane_id_w(NUM_LANES);

    logic [NUM_LANES-1:0]             w_gnt;
    logic [LW-1:0]                    w_gnt_idx;
    logic                             w_any;
    logic [NUM_LANES:0][ADDR_W-1:0]   w_addr_chain;
    logic [NUM_LANES:0][DATA_W-1:0]   w_wdata_chain;
    logic [NUM_LANES:0]               w_we_chain;
    logic                             w_we_sel;
    logic                             w_load;

    logic [ADDR_W-1:0]                r_addr;
    logic [DATA_W-1:0]                r_data;
    logic                             r_wren;
    logic [READ_LAT-1:0]              r_pv;
    logic [READ_LAT-1:0][LW-1:0]      r_pid;
    logic [NUM_LANES-1:0]             r_rvalid;
    logic [DATA_W-1:0]                r_rdata;

    rr_grant #(
        .NUM_LANES (NUM_LANES),
        .ARB_MODE  (ARB_MODE)
    ) u_grant (
        .clock     (clock),
        .reset     (reset),
        .i_req     (bus.lane_req),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    assign w_addr_chain[0]  = '0;
    assign w_wdata_chain[0] = '0;
    assign w_we_chain[0]    = 1'b0;

    // Grant is one-hot, so an AND-OR chain selects the winning lane's fields.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_mux
            assign w_addr_chain[gi + 1]  = w_addr_chain[gi]
                                         | (w_gnt[gi] ? bus.lane_addr[gi*ADDR_W +: ADDR_W] : '0);
            assign w_wdata_chain[gi + 1] = w_wdata_chain[gi]
                                         | (w_gnt[gi] ? bus.lane_wdata[gi*DATA_W +: DATA_W] : '0);
            assign w_we_chain[gi + 1]    = w_we_chain[gi] | (w_gnt[gi] & bus.lane_we[gi]);
        end
    endgenerate

    assign w_we_sel = w_we_chain[NUM_LANES];
    assign w_load   = w_any & ~w_we_sel;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr <= '0;
            r_data <= '0;
            r_wren <= 1'b0;
        end else begin
            r_wren <= w_any & w_we_sel;
            if (w_any) begin
                r_addr <= w_addr_chain[NUM_LANES];
                r_data <= w_wdata_chain[NUM_LANES];
            end
        end
    end

    // Stage READ_LAT-1 lines up with q_dmem becoming valid for that request.
    generate
        for (genvar gi = 0; gi < READ_LAT; gi++) begin : g_ret
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_pv[gi]  <= 1'b0;
                    r_pid[gi] <= '0;
                end else if (gi == 0) begin
                    r_pv[gi]  <= w_load;
                    r_pid[gi] <= w_gnt_idx;
                end else begin
                    r_pv[gi]  <= r_pv[(gi == 0) ? 0 : gi - 1];
                    r_pid[gi] <= r_pid[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= r_pv[READ_LAT-1] ? (NUM_LANES'(1) << r_pid[READ_LAT-1]) : '0;
            if (r_pv[READ_LAT-1]) begin
                r_rdata <= bus.q_dmem;
            end
        end
    end

    assign bus.lane_gnt     = w_gnt;
    assign bus.lane_rvalid  = r_rvalid;
    assign bus.lane_rdata   = r_rdata;
    assign bus.address_dmem = r_addr;
    assign bus.data         = r_data;
    assign bus.wren         = r_wren;

endmodule
